dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl.sv | 118 +++++++++++
 tb/tb_dmem_ctrl.sv | 107 ++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: word-organised data memory with sized loads/stores, wait states and registered responses.
// Optional DMEM_FAULT_EN flags misaligned/reserved-size accesses instead of masking them.
module dmem_ctrl #(
    parameter int n    = 32,
    parameter int r    = 6,
    parameter int WAIT = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_write,
    input  logic [1:0]   req_size,
    input  logic         req_unsigned,
    input  logic [n-1:0] addr,
    input  logic [n-1:0] wdata,
    output logic         resp_valid,
    output logic [n-1:0] rdata,
    output logic         resp_fault
);
    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    localparam logic [3:0] WLD = 4'(WAIT > 0 ? WAIT - 1 : 0);
    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [n-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic write_q, write_d, uns_q, uns_d, fault_q, fault_d;
    logic [1:0] size_q, size_d;
    logic [n-1:0] mem [2**r];
    logic idle, accept, commit, c_write, c_uns, byt, half, fault, unused_ok;
    logic [1:0] c_size;
    logic [n-1:0] c_addr, c_wdata, rd_word, sh, ld, wd;
    logic [3:0] be;
    logic [4:0] shamt;
    // While idle the live inputs drive the datapath so a zero-wait access can commit on its acceptance edge.
    always_comb begin
        idle      = state_q == IDLE;
        accept    = idle && req_valid;
        commit    = (accept && WAIT == 0) || (state_q == BUSY && cnt_q == 4'd0);
        c_addr    = idle ? addr : addr_q;
        c_wdata   = idle ? wdata : wdata_q;
        c_write   = idle ? req_write : write_q;
        c_size    = idle ? req_size : size_q;
        c_uns     = idle ? req_unsigned : uns_q;
        unused_ok = ^c_addr[n-1:r+2];
        byt       = c_size == 2'b00;
        half      = c_size == 2'b01;
`ifdef DMEM_FAULT_EN
        fault     = (half && c_addr[0]) || (c_size == 2'b10 && c_addr[1:0] != 2'b00) || c_size == 2'b11;
`else
        fault     = 1'b0;
`endif
        be        = byt ? 4'b0001 << c_addr[1:0] : half ? (c_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd        = byt ? {4{c_wdata[7:0]}} : half ? {2{c_wdata[15:0]}} : c_wdata;
        rd_word   = mem[c_addr[r+1:2]];
        shamt     = byt ? {c_addr[1:0], 3'b000} : half ? {c_addr[1], 4'b0000} : 5'd0;
        sh        = rd_word >> shamt;
        ld        = byt ? {{24{~c_uns & sh[7]}}, sh[7:0]} : half ? {{16{~c_uns & sh[15]}}, sh[15:0]} : sh;
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        write_d   = write_q;
        size_d    = size_q;
        uns_d     = uns_q;
        rdata_d   = rdata_q;
        fault_d   = fault_q;
        if (accept) begin
            state_d = WAIT == 0 ? RESP : BUSY;
            cnt_d   = WLD;
            addr_d  = addr;
            wdata_d = wdata;
            write_d = req_write;
            size_d  = req_size;
            uns_d   = req_unsigned;
        end
        if (state_q == BUSY) begin
            cnt_d   = cnt_q - 4'd1;
            state_d = cnt_q == 4'd0 ? RESP : BUSY;
        end
        if (state_q == RESP) state_d = IDLE;
        if (commit) begin
            fault_d = fault;
            rdata_d = fault ? '0 : c_write ? rdata_q : ld;
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            write_q <= write_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && commit && c_write && !fault)
            for (int i = 0; i < 4; i++)
                if (be[i]) mem[c_addr[r+1:2]][8*i +: 8] <= wd[8*i +: 8];
    end
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign rdata      = rdata_q;
    assign resp_fault = fault_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed checks of dmem_ctrl with WAIT=2 and WAIT=0 instances sharing one stimulus bus.
module tb_dmem_ctrl;
`ifdef DMEM_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif
    logic clk = 0, reset = 1, req_valid = 0, req_write = 0, req_unsigned = 0, sel = 0;
    logic [1:0] req_size = 0;
    logic [31:0] addr = 0, wdata = 0;
    logic rdy2, rv2, f2, rdy0, rv0, f0, rdy, rv, resp_fault;
    logic [31:0] rd2, rd0, rdata;
    int errs = 0, checks = 0, lat, low, seen;
    logic [31:0] got;
    logic gflt, rdy_after, rv_after;
    always #5 clk = ~clk;
    assign rdy        = sel ? rdy0 : rdy2;
    assign rv         = sel ? rv0 : rv2;
    assign rdata      = sel ? rd0 : rd2;
    assign resp_fault = sel ? f0 : f2;
    dmem_ctrl #(.n(32), .r(6), .WAIT(2)) u_w2 (
        .clk(clk), .reset(reset), .req_valid(req_valid & ~sel), .req_ready(rdy2),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .addr(addr), .wdata(wdata), .resp_valid(rv2), .rdata(rd2), .resp_fault(f2));
    dmem_ctrl #(.n(32), .r(6), .WAIT(0)) u_w0 (
        .clk(clk), .reset(reset), .req_valid(req_valid & sel), .req_ready(rdy0),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .addr(addr), .wdata(wdata), .resp_valid(rv0), .rdata(rd0), .resp_fault(f0));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask
    // Request inputs are scrambled right after acceptance; the DUT must use its captured copy.
    task automatic acc(input logic w, input logic [1:0] sz, input logic u, input logic [31:0] a, input logic [31:0] d);
        int k = 0;
        @(negedge clk);
        while (!rdy && k < 50) begin @(negedge clk); k++; end
        req_valid = 1; req_write = w; req_size = sz; req_unsigned = u; addr = a; wdata = d;
        @(negedge clk);
        req_valid = 0; req_write = ~w; req_size = ~sz; req_unsigned = ~u; addr = 32'hFFFF_FFFF; wdata = 32'h0BAD_0BAD;
        lat = 1; low = 0;
        while (!rv && lat < 50) begin low += int'(!rdy); @(negedge clk); lat++; end
        low += int'(!rdy);
        got = rdata; gflt = resp_fault;
        @(negedge clk);
        rdy_after = rdy; rv_after = rv;
    endtask
    initial begin
        repeat (3) @(negedge clk);
        sel = 0;
        check("rst_ready2", rdy, 1); check("rst_valid2", rv, 0); check("rst_rdata2", rdata, 0); check("rst_fault2", resp_fault, 0);
        sel = 1;
        check("rst_ready0", rdy, 1); check("rst_valid0", rv, 0); check("rst_rdata0", rdata, 0); check("rst_fault0", resp_fault, 0);
        sel = 0; reset = 0;
        acc(1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
        check("sw_lat", lat, 3); check("sw_ready_low", low, 3); check("sw_strobe_1cyc", rv_after, 0);
        check("sw_ready_back", rdy_after, 1); check("sw_fault", gflt, 0);
        acc(0, 2'b10, 0, 32'h10, 0);
        check("lw_data", got, 32'hDEAD_BEEF); check("lw_lat", lat, 3);
        acc(1, 2'b10, 0, 32'h10, 32'h1122_3344);
        acc(1, 2'b00, 0, 32'h13, 32'h1234_5680);
        acc(0, 2'b00, 0, 32'h13, 0); check("lb_signed", got, 32'hFFFF_FF80);
        acc(0, 2'b00, 1, 32'h13, 0); check("lbu", got, 32'h0000_0080);
        acc(0, 2'b10, 0, 32'h10, 0); check("lw_after_sb", got, 32'h8022_3344);
        acc(1, 2'b10, 0, 32'h20, 0);
        acc(1, 2'b01, 0, 32'h22, 32'h5A5A_A5A5); check("st_keeps_rdata", got, 32'h8022_3344);
        acc(0, 2'b01, 0, 32'h22, 0); check("lh_signed", got, 32'hFFFF_A5A5);
        acc(0, 2'b01, 1, 32'h22, 0); check("lhu", got, 32'h0000_A5A5);
        acc(0, 2'b10, 0, 32'h20, 0); check("lw_after_sh", got, 32'hA5A5_0000);
        acc(0, 2'b00, 0, 32'h22, 0); check("lb_lane2", got, 32'hFFFF_FFA5);
        acc(0, 2'b00, 0, 32'h21, 0); check("lb_lane1", got, 32'h0000_0000);
        acc(1, 2'b10, 0, 32'h04, 32'h0102_0304);
        acc(0, 2'b10, 0, 32'h04, 0); check("lw_04", got, 32'h0102_0304);
        acc(1, 2'b10, 0, 32'h06, 32'h9988_7766);
        check("mis_fault", gflt, FE); check("mis_rdata", got, FE ? 32'h0 : 32'h0102_0304);
        acc(0, 2'b10, 0, 32'h04, 0);
        check("mis_ram", got, FE ? 32'h0102_0304 : 32'h9988_7766); check("mis_ld_fault", gflt, 0);
        acc(1, 2'b10, 0, 32'h08, 32'h5566_7788);
        acc(0, 2'b10, 0, 32'h08, 0); check("lw_08", got, 32'h5566_7788);
        @(negedge clk);
        req_valid = 1; req_write = 1; req_size = 2'b10; addr = 32'h08; wdata = 32'hCAFE_F00D;
        @(negedge clk);
        req_valid = 0; reset = 1;
        @(negedge clk);
        reset = 0;
        check("rst_busy_ready", rdy, 1); check("rst_busy_rdata", rdata, 0); check("rst_busy_fault", resp_fault, 0);
        seen = 0;
        repeat (5) begin seen += int'(rv); @(negedge clk); end
        check("rst_busy_no_resp", seen, 0);
        acc(0, 2'b10, 0, 32'h08, 0); check("rst_busy_old", got, 32'h5566_7788);
        sel = 1;
        acc(1, 2'b10, 0, 32'h100, 32'h1234_5678);
        check("w0_sw_lat", lat, 1); check("w0_ready_low", low, 1); check("w0_ready_back", rdy_after, 1);
        acc(0, 2'b10, 0, 32'h0, 0); check("w0_alias", got, 32'h1234_5678); check("w0_lw_lat", lat, 1);
        @(negedge clk);
        req_valid = 1; req_write = 0; req_size = 2'b10; addr = 32'h0; seen = 0;
        repeat (8) begin @(negedge clk); seen += int'(rv); end
        req_valid = 0;
        check("w0_stream_resps", seen, 4); check("w0_stream_data", rdata, 32'h1234_5678);
        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
